// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority-vote sampling
//
// Receives DATA_BITS data bits LSB first, optional even/odd parity and
// STOP_BITS stop bits, and presents each completed word in a valid/ready
// holding register.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   serial_in   asynchronous UART line, idle high
//   out_data    received word
//   out_valid   out_data and error flags valid, held until accepted
//   out_ready   consumer accepts when out_valid && out_ready
//   parity_err  parity mismatch on out_data (always 0 without parity)
//   frame_err   a stop bit of out_data's frame sampled 0
//   overrun     1-cycle pulse: a new frame overwrote an unaccepted word
//   break_det   1-cycle pulse: break frame seen
//   busy        receiver is inside a frame or waiting out a break
module uart_rx_param #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BRK_WAIT
    } state_t;

    state_t               state, state_n;
    logic                 s1, s2;
    logic [2:0]           v;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_q, par_n;
    logic                 ferr_q, ferr_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, perr_out_n, ferr_out_n, overrun_n, brk_n;
    logic                 vote, bit_done, par_calc, perr_calc, brk_cand;

    assign vote      = (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    assign bit_done  = (cnt == CNT_LAST);
    assign par_calc  = (PARITY_MODE == 2) ? ~(^shift) : ^shift;
    assign perr_calc = (PARITY_MODE != 0) && (par_q != par_calc);
    // A break is an all-zero frame whose parity and first stop bit are also 0.
    assign brk_cand  = (shift == '0) && ((PARITY_MODE == 0) || !par_q);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s1         <= 1'b1;
            s2         <= 1'b1;
            v          <= 3'b111;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shift      <= '0;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            state      <= state_n;
            s1         <= serial_in;
            s2         <= s1;
            v          <= {v[1:0], s2};
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            shift      <= shift_n;
            par_q      <= par_n;
            ferr_q     <= ferr_n;
            out_data   <= data_n;
            out_valid  <= valid_n;
            parity_err <= perr_out_n;
            frame_err  <= ferr_out_n;
            overrun    <= overrun_n;
            break_det  <= brk_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        stop_idx_n = stop_idx;
        shift_n    = shift;
        par_n      = par_q;
        ferr_n     = ferr_q;
        data_n     = out_data;
        valid_n    = out_valid && !out_ready;
        perr_out_n = parity_err;
        ferr_out_n = frame_err;
        overrun_n  = 1'b0;
        brk_n      = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!s2) state_n = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n = '0;
                    if (!vote) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;   // start-bit glitch
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = vote;
                    if (bit_idx == IDX_LAST) begin
                        state_n    = (PARITY_MODE != 0) ? PARITY : STOP;
                        stop_idx_n = 1'b0;
                        ferr_n     = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    cnt_n   = '0;
                    par_n   = vote;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (!stop_idx && brk_cand && !vote) begin
                        brk_n   = 1'b1;
                        state_n = BRK_WAIT;
                    end else if (stop_idx == STOP_LAST) begin
                        // Leave at the stop-bit centre so a back-to-back
                        // start edge is seen half a bit early.
                        state_n    = IDLE;
                        data_n     = shift;
                        perr_out_n = perr_calc;
                        ferr_out_n = ferr_q | !vote;
                        valid_n    = 1'b1;
                        overrun_n  = out_valid && !out_ready;
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                        ferr_n     = ferr_q | !vote;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BRK_WAIT: begin
                cnt_n = '0;
                if (s2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (8N1 and 8E1 instances)
module tb_uart_rx_param;

    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst, serial_in, out_ready;

    logic [7:0] a_data, b_data;
    logic a_valid, a_perr, a_ferr, a_ovr, a_brk, a_busy;
    logic b_valid, b_perr, b_ferr, b_ovr, b_brk, b_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start = 0;

    int a_vcnt, a_first, a_ovrc, a_brkc, a_busy_last;
    int b_vcnt, b_first;
    logic [7:0] a_cap_data, b_cap_data;
    logic a_cap_perr, a_cap_ferr, b_cap_perr, b_cap_ferr;

    uart_rx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) u_8n1 (
        .clk(clk), .rst(rst), .serial_in(serial_in),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready),
        .parity_err(a_perr), .frame_err(a_ferr), .overrun(a_ovr),
        .break_det(a_brk), .busy(a_busy)
    );

    uart_rx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .PARITY_MODE(1)) u_8e1 (
        .clk(clk), .rst(rst), .serial_in(serial_in),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready),
        .parity_err(b_perr), .frame_err(b_ferr), .overrun(b_ovr),
        .break_det(b_brk), .busy(b_busy)
    );

    always #5 clk = ~clk;

    // Observes outputs 1 time unit after each edge; edge index is cyc - start.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (a_valid) begin
            if (a_vcnt == 0) begin
                a_first = cyc - start; a_cap_data = a_data;
                a_cap_perr = a_perr; a_cap_ferr = a_ferr;
            end
            a_vcnt = a_vcnt + 1;
        end
        if (b_valid) begin
            if (b_vcnt == 0) begin
                b_first = cyc - start; b_cap_data = b_data;
                b_cap_perr = b_perr; b_cap_ferr = b_ferr;
            end
            b_vcnt = b_vcnt + 1;
        end
        if (a_ovr) a_ovrc = a_ovrc + 1;
        if (a_brk) a_brkc = a_brkc + 1;
        if (a_busy) a_busy_last = cyc - start;
    end

    task automatic clear_mon();
        a_vcnt = 0; a_first = -1; a_ovrc = 0; a_brkc = 0; a_busy_last = -1;
        b_vcnt = 0; b_first = -1;
        a_cap_data = 8'hxx; b_cap_data = 8'hxx;
    endtask

    task automatic drive_level(input logic b, input int n, input bit mark);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (mark && c == 0) start = cyc + 1;
            serial_in = b;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input bit has_par,
                              input logic pbit, input bit spike);
        logic [10:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
        n = 10;
        if (has_par) begin
            bits[9] = pbit;
            n = 11;
        end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) start = cyc + 1;
                serial_in = (spike && c == 3) ? ~bits[k] : bits[k];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; serial_in = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got %h exp 00", a_data); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        checks++; if ({a_perr, a_ferr, a_ovr, a_brk} !== 4'b0) begin failures++; $display("FAIL reset_flags got %b exp 0000", {a_perr, a_ferr, a_ovr, a_brk}); end
        checks++; if ({b_valid, b_busy, b_perr, b_ferr} !== 4'b0) begin failures++; $display("FAIL reset_b got %b exp 0000", {b_valid, b_busy, b_perr, b_ferr}); end
        drive_level(1'b1, 20, 1'b0);
    endtask

    task automatic test_basic_8n1();
        clear_mon();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        drive_level(1'b1, 40, 1'b0);
        // 3 + HALF(4) + 9 bits * 10 = 97
        checks++; if (a_first !== 97) begin failures++; $display("FAIL 8n1_latency got %0d exp 97", a_first); end
        checks++; if (a_vcnt !== 1) begin failures++; $display("FAIL 8n1_valid_cycles got %0d exp 1", a_vcnt); end
        checks++; if (a_cap_data !== 8'h55) begin failures++; $display("FAIL 8n1_data got %h exp 55", a_cap_data); end
        checks++; if ({a_cap_perr, a_cap_ferr} !== 2'b00) begin failures++; $display("FAIL 8n1_flags got %b exp 00", {a_cap_perr, a_cap_ferr}); end
    endtask

    task automatic test_parity();
        // 0xA3 has four ones: the even parity bit is 0, so sending 1 is an error.
        clear_mon();
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0);
        drive_level(1'b1, 200, 1'b0);
        checks++; if (b_first !== 107) begin failures++; $display("FAIL par_latency got %0d exp 107", b_first); end
        checks++; if (b_cap_data !== 8'hA3) begin failures++; $display("FAIL par_data got %h exp a3", b_cap_data); end
        checks++; if (b_cap_perr !== 1'b1) begin failures++; $display("FAIL par_err_set got %b exp 1", b_cap_perr); end
        checks++; if (b_cap_ferr !== 1'b0) begin failures++; $display("FAIL par_ferr got %b exp 0", b_cap_ferr); end
        clear_mon();
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        drive_level(1'b1, 200, 1'b0);
        checks++; if (b_vcnt !== 1) begin failures++; $display("FAIL par2_valid_cycles got %0d exp 1", b_vcnt); end
        checks++; if (b_cap_data !== 8'hA3) begin failures++; $display("FAIL par2_data got %h exp a3", b_cap_data); end
        checks++; if (b_cap_perr !== 1'b0) begin failures++; $display("FAIL par_err_clear got %b exp 0", b_cap_perr); end
    endtask

    task automatic test_glitch();
        clear_mon();
        drive_level(1'b0, 2, 1'b1);
        drive_level(1'b1, 40, 1'b0);
        // Busy after edges 2..6; the start-centre vote at edge 7 rejects it.
        checks++; if (a_busy_last !== 6) begin failures++; $display("FAIL glitch_busy_last got %0d exp 6", a_busy_last); end
        checks++; if (a_vcnt !== 0) begin failures++; $display("FAIL glitch_valid got %0d exp 0", a_vcnt); end
        checks++; if (b_vcnt !== 0) begin failures++; $display("FAIL glitch_valid_b got %0d exp 0", b_vcnt); end
    endtask

    task automatic test_vote();
        clear_mon();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        drive_level(1'b1, 200, 1'b0);
        checks++; if (a_first !== 97) begin failures++; $display("FAIL vote_latency got %0d exp 97", a_first); end
        checks++; if (a_cap_data !== 8'h0F) begin failures++; $display("FAIL vote_data got %h exp 0f", a_cap_data); end
        checks++; if ({a_cap_perr, a_cap_ferr} !== 2'b00) begin failures++; $display("FAIL vote_flags got %b exp 00", {a_cap_perr, a_cap_ferr}); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        drive_level(1'b1, 10, 1'b0);
        checks++; if (a_cap_data !== 8'h11) begin failures++; $display("FAIL b2b_first_data got %h exp 11", a_cap_data); end
        checks++; if (a_ovrc !== 1) begin failures++; $display("FAIL b2b_overrun got %0d exp 1", a_ovrc); end
        checks++; if (a_data !== 8'h22) begin failures++; $display("FAIL b2b_data got %h exp 22", a_data); end
        checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL b2b_held got %b exp 1", a_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL b2b_accept got %b exp 0", a_valid); end
        drive_level(1'b1, 200, 1'b0);
    endtask

    task automatic test_break_and_reset();
        clear_mon();
        drive_level(1'b0, 15 * CPB, 1'b1);
        drive_level(1'b1, 30, 1'b0);
        checks++; if (a_brkc !== 1) begin failures++; $display("FAIL break_pulses got %0d exp 1", a_brkc); end
        checks++; if (a_vcnt !== 0) begin failures++; $display("FAIL break_valid got %0d exp 0", a_vcnt); end
        checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL break_idle got %b exp 0", a_busy); end
        clear_mon();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
        drive_level(1'b1, 30, 1'b0);
        checks++; if (a_vcnt !== 1) begin failures++; $display("FAIL after_break_valid got %0d exp 1", a_vcnt); end
        checks++; if (a_cap_data !== 8'h7E) begin failures++; $display("FAIL after_break_data got %h exp 7e", a_cap_data); end
        checks++; if ({a_cap_perr, a_cap_ferr} !== 2'b00) begin failures++; $display("FAIL after_break_flags got %b exp 00", {a_cap_perr, a_cap_ferr}); end
        // Start a 0xFF frame, reset two bits in; the rest of the line stays high.
        drive_level(1'b0, CPB, 1'b1);
        drive_level(1'b1, 2 * CPB, 1'b0);
        checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL midframe_busy got %b exp 1", a_busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL rst_data got %h exp 00", a_data); end
        checks++; if ({a_valid, a_busy, a_perr, a_ferr, a_ovr, a_brk} !== 6'b0) begin failures++; $display("FAIL rst_outputs got %b exp 000000", {a_valid, a_busy, a_perr, a_ferr, a_ovr, a_brk}); end
        drive_level(1'b1, 120, 1'b0);
        checks++; if (a_vcnt !== 0) begin failures++; $display("FAIL rst_no_delivery got %0d exp 0", a_vcnt); end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic_8n1();
        test_parity();
        test_glitch();
        test_vote();
        test_back_to_back();
        test_break_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
